// File: rtl/ahb_matrix_input_stage.sv
// AHB matrix per-master input stage: holds a stalled address phase until accepted.
// Optional address-user sideband enabled with AHB_MATRIX_INPUT_AUSER_EN.
module ahb_matrix_input_stage #(
  parameter int AUSER_WIDTH = 32
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
`ifdef AHB_MATRIX_INPUT_AUSER_EN
  input  logic [AUSER_WIDTH-1:0] HAUSERS,
  output logic [AUSER_WIDTH-1:0] auser_in,
`endif
  input  logic        active_in,
  input  logic        readyout_in,
  input  logic [1:0]  resp_in,
  output logic        sel_in,
  output logic [31:0] addr_in,
  output logic [1:0]  trans_in,
  output logic        write_in,
  output logic [2:0]  size_in,
  output logic [2:0]  burst_in,
  output logic [3:0]  prot_in,
  output logic        lock_in,
  output logic        held_tran,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS
);

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } hold_t;

  if (AUSER_WIDTH < 1) begin : g_bad_width
    $error("AUSER_WIDTH must be at least 1");
  end

  hold_t held;
  hold_t live;
  hold_t pres;
  logic  pend_tran;
  logic  load;

  assign live = '{
    sel:   HSELS,
    addr:  HADDRS,
    trans: HTRANSS,
    write: HWRITES,
    size:  HSIZES,
    burst: HBURSTS,
    prot:  HPROTS,
    lock:  HMASTLOCKS
  };

  assign load = HREADYS & HSELS & HTRANSS[1]
              & ~active_in & ~pend_tran;

  // Capture a rejected address phase; release once the target goes active.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_tran <= 1'b0;
      held      <= '0;
    end else if (pend_tran && active_in) begin
      pend_tran <= 1'b0;
    end else if (load) begin
      pend_tran <= 1'b1;
      held      <= live;
    end
  end

`ifdef AHB_MATRIX_INPUT_AUSER_EN
  logic [AUSER_WIDTH-1:0] held_auser;

  // Sideband is captured alongside the address.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      held_auser <= '0;
    end else if (load) begin
      held_auser <= HAUSERS;
    end
  end

  assign auser_in = pend_tran ? held_auser : HAUSERS;
`endif

  assign pres = pend_tran ? held : live;

  // Held SEQ goes back through arbitration, so it restarts as NONSEQ.
  always_comb begin
    trans_in = pres.trans;
    if (pend_tran && pres.trans == 2'b11) begin
      trans_in = 2'b10;
    end
  end

  assign sel_in     = pres.sel;
  assign addr_in    = pres.addr;
  assign write_in   = pres.write;
  assign size_in    = pres.size;
  assign burst_in   = pres.burst;
  assign prot_in    = pres.prot;
  assign lock_in    = pres.lock;
  assign held_tran  = pend_tran;
  assign HREADYOUTS = pend_tran ? 1'b0 : readyout_in;
  assign HRESPS     = pend_tran ? 2'b00 : resp_in;

endmodule
